// File: rtl/dmg_pkg.sv
// Shared definitions for the DMG timer block.
// Register offsets, TAC encodings and timer state.
package dmg_pkg;

  localparam logic [1:0] REG_DIV  = 2'b00;
  localparam logic [1:0] REG_TIMA = 2'b01;
  localparam logic [1:0] REG_TMA  = 2'b10;
  localparam logic [1:0] REG_TAC  = 2'b11;

  localparam logic [1:0] TAC_SEL_4096   = 2'b00;
  localparam logic [1:0] TAC_SEL_262144 = 2'b01;
  localparam logic [1:0] TAC_SEL_65536  = 2'b10;
  localparam logic [1:0] TAC_SEL_16384  = 2'b11;

  localparam logic [7:0] TAC_RD_MASK = 8'hF8;

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    OVF    = 2'b01,
    RELOAD = 2'b10
  } tmr_state_e;

  function automatic logic [7:0] tac_rd(input logic [2:0] tac);
    return TAC_RD_MASK | {5'b00000, tac};
  endfunction

endpackage

// File: rtl/tima_tick_sel.sv
// Tap select, enable gate and falling-edge detector.
// Any fall of the gated tap counts, including TAC/DIV glitches.
module tima_tick_sel
  import dmg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] tac,
  input  logic       tap_4096,
  input  logic       tap_262144,
  input  logic       tap_65536,
  input  logic       tap_16384,
  output logic       tick
);

  logic tap_sel;
  logic g;
  logic g_prev_q;
  logic g_prev_d;

  // 4:1 divider tap mux
  always_comb begin
    tap_sel = 1'b0;
    unique case (tac[1:0])
      TAC_SEL_4096:   tap_sel = tap_4096;
      TAC_SEL_262144: tap_sel = tap_262144;
      TAC_SEL_65536:  tap_sel = tap_65536;
      TAC_SEL_16384:  tap_sel = tap_16384;
    endcase
  end

  // gate and edge detect
  always_comb begin
    g        = tac[2] & tap_sel;
    g_prev_d = g;
    tick     = g_prev_q & ~g;
  end

  // previous gated level
  always_ff @(posedge clk) begin
    if (reset) g_prev_q <= 1'b0;
    else       g_prev_q <= g_prev_d;
  end

endmodule

// File: rtl/dmg_timer.sv
// DMG programmable timer: TIMA/TMA/TAC with delayed reload.
// Overflow shows 00 for RELOAD_DELAY cycles, then reloads and IRQs.
module dmg_timer
  import dmg_pkg::*;
#(
  parameter int RELOAD_DELAY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tap_4096,
  input  logic       tap_262144,
  input  logic       tap_65536,
  input  logic       tap_16384,
  input  logic       ff04_ff07,
  input  logic       tola_na1,
  input  logic       tovy_na0,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic       int_timer
);

  localparam logic [7:0] OVF_LAST = 8'(RELOAD_DELAY - 1);

  tmr_state_e state_q, state_d;
  logic [7:0] tima_q, tima_d;
  logic [7:0] tma_q, tma_d;
  logic [2:0] tac_q, tac_d;
  logic       int_q, int_d;
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  logic [1:0] addr;
  logic       wr_tima;
  logic       wr_tma;
  logic       wr_tac;
  logic       tick;
  logic       ovf_done;
  logic [8:0] tima_inc;

  tima_tick_sel u_tick (
    .clk        (clk),
    .reset      (reset),
    .tac        (tac_q),
    .tap_4096   (tap_4096),
    .tap_262144 (tap_262144),
    .tap_65536  (tap_65536),
    .tap_16384  (tap_16384),
    .tick       (tick)
  );

  // bus address decode and write strobes
  always_comb begin
    addr     = {~tola_na1, ~tovy_na0};
    wr_tima  = cpu_wr & ff04_ff07 & (addr == REG_TIMA);
    wr_tma   = cpu_wr & ff04_ff07 & (addr == REG_TMA);
    wr_tac   = cpu_wr & ff04_ff07 & (addr == REG_TAC);
    ovf_done = (ovf_cnt_q == OVF_LAST);
    tima_inc = {1'b0, tima_q} + 9'd1;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NORMAL: begin
        if (!wr_tima && tick && tima_inc[8])
          state_d = OVF;
      end
      OVF: begin
        if (wr_tima)       state_d = NORMAL;
        else if (ovf_done) state_d = RELOAD;
      end
      RELOAD:  state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  // register datapath and IRQ
  always_comb begin
    tima_d    = tima_q;
    tma_d     = wr_tma ? d_in : tma_q;
    tac_d     = wr_tac ? d_in[2:0] : tac_q;
    int_d     = 1'b0;
    ovf_cnt_d = 8'h00;
    unique case (state_q)
      NORMAL: begin
        if (wr_tima)   tima_d = d_in;
        else if (tick) tima_d = tima_inc[7:0];
      end
      OVF: begin
        if (wr_tima) begin
          tima_d = d_in;
        end else if (ovf_done) begin
          tima_d = tma_d;
          int_d  = 1'b1;
        end else begin
          ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
      end
      RELOAD: begin
        if (wr_tma) tima_d = d_in;
      end
      default: ;
    endcase
  end

  // state and register flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= NORMAL;
      tima_q    <= 8'h00;
      tma_q     <= 8'h00;
      tac_q     <= 3'b000;
      int_q     <= 1'b0;
      ovf_cnt_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      tima_q    <= tima_d;
      tma_q     <= tma_d;
      tac_q     <= tac_d;
      int_q     <= int_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // combinational read path
  always_comb begin
    d_oe      = cpu_rd & ff04_ff07 & (addr != REG_DIV);
    d_out     = 8'h00;
    int_timer = int_q;
    if (d_oe) begin
      unique case (addr)
        REG_TIMA: d_out = tima_q;
        REG_TMA:  d_out = tma_q;
        REG_TAC:  d_out = tac_rd(tac_q);
        default:  d_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_dmg_timer.sv
// Bench for dmg_timer: directed quirks plus random traffic.
// A flag-based reference model is compared every cycle.
module tb_dmg_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tap_4096 = 1'b0;
  logic       tap_262144 = 1'b0;
  logic       tap_65536 = 1'b0;
  logic       tap_16384 = 1'b0;
  logic       ff04_ff07 = 1'b0;
  logic       tola_na1 = 1'b1;
  logic       tovy_na0 = 1'b1;
  logic       cpu_wr = 1'b0;
  logic       cpu_rd = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic [7:0] d_out;
  logic       d_oe;
  logic       int_timer;

  int n_chk = 0;
  int n_fail = 0;
  int irq_cnt = 0;
  bit chk_en = 1'b0;

  // reference model state
  int  m_tima = 0;
  int  m_tma = 0;
  int  m_tac = 0;
  bit  m_g = 1'b0;
  bit  m_ovf = 1'b0;
  bit  m_rel = 1'b0;
  bit  m_irq = 1'b0;

  dmg_timer #(.RELOAD_DELAY(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .tap_4096   (tap_4096),
    .tap_262144 (tap_262144),
    .tap_65536  (tap_65536),
    .tap_16384  (tap_16384),
    .ff04_ff07  (ff04_ff07),
    .tola_na1   (tola_na1),
    .tovy_na0   (tovy_na0),
    .cpu_wr     (cpu_wr),
    .cpu_rd     (cpu_rd),
    .d_in       (d_in),
    .d_out      (d_out),
    .d_oe       (d_oe),
    .int_timer  (int_timer)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // model: advance one clock using the inputs seen at the edge
  always @(posedge clk) begin
    int  a;
    int  new_tma;
    bit  wtima, wtma, wtac, g, tick;
    logic [3:0] tv;
    if (reset) begin
      m_tima = 0; m_tma = 0; m_tac = 0;
      m_g = 0; m_ovf = 0; m_rel = 0; m_irq = 0;
    end else begin
      a     = (tola_na1 ? 0 : 2) + (tovy_na0 ? 0 : 1);
      wtima = cpu_wr && ff04_ff07 && a == 1;
      wtma  = cpu_wr && ff04_ff07 && a == 2;
      wtac  = cpu_wr && ff04_ff07 && a == 3;
      tv    = {tap_16384, tap_65536, tap_262144, tap_4096};
      g     = (m_tac >= 4) && tv[m_tac % 4];
      tick  = m_g && !g;
      new_tma = wtma ? int'(d_in) : m_tma;
      m_irq = 0;
      if (m_ovf) begin
        m_ovf = 0;
        if (wtima) m_tima = d_in;
        else begin
          m_tima = new_tma;
          m_irq = 1;
          m_rel = 1;
        end
      end else if (m_rel) begin
        m_rel = 0;
        if (wtma) m_tima = d_in;
      end else if (wtima) begin
        m_tima = d_in;
      end else if (tick) begin
        m_tima = m_tima + 1;
        if (m_tima > 255) begin
          m_tima = 0;
          m_ovf = 1;
        end
      end
      m_tma = new_tma;
      if (wtac) m_tac = d_in % 8;
      m_g = g;
    end
  end

  // compare process: outputs vs model, mid-cycle
  always @(negedge clk) begin
    int a;
    bit oe;
    int rv;
    if (int_timer === 1'b1) irq_cnt++;
    if (chk_en) begin
      a  = (tola_na1 ? 0 : 2) + (tovy_na0 ? 0 : 1);
      oe = cpu_rd && ff04_ff07 && a != 0;
      rv = 0;
      if (oe) rv = (a == 1) ? m_tima : (a == 2) ? m_tma : 248 + m_tac;
      check("model_oe", {7'd0, d_oe}, {7'd0, oe});
      check("model_dout", d_out, rv[7:0]);
      check("model_irq", {7'd0, int_timer}, {7'd0, m_irq});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [1:0] a);
    ff04_ff07 = 1'b1;
    tola_na1  = ~a[1];
    tovy_na0  = ~a[0];
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    set_addr(a);
    cpu_rd = 1'b0;
    cpu_wr = 1'b1;
    d_in   = d;
    step();
    cpu_wr = 1'b0;
    ff04_ff07 = 1'b0;
  endtask

  task automatic chk_read(input logic [1:0] a, input logic [7:0] e,
                          input string name);
    set_addr(a);
    cpu_rd = 1'b1;
    @(negedge clk);
    check(name, d_out, e);
  endtask

  task automatic fall_262144();
    tap_262144 = 1'b1;
    step();
    tap_262144 = 1'b0;
    step();
  endtask

  initial begin
    int irq0;
    reset = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;

    chk_read(2'b11, 8'hF8, "rst_tac");
    chk_read(2'b01, 8'h00, "rst_tima");
    chk_read(2'b10, 8'h00, "rst_tma");
    check("rst_irq", {7'd0, int_timer}, 8'h00);
    chk_read(2'b00, 8'h00, "div_dout");
    check("div_oe", {7'd0, d_oe}, 8'h00);
    step();

    // counting
    irq0 = irq_cnt;
    wr(2'b11, 8'h05);
    wr(2'b01, 8'h00);
    for (int i = 0; i < 10; i++) fall_262144();
    chk_read(2'b01, 8'h0A, "count10");
    check("model_count10", m_tima[7:0], 8'h0A);
    check("count_noirq", 8'(irq_cnt - irq0), 8'h00);
    step();

    // overflow and reload
    wr(2'b10, 8'hC0);
    wr(2'b01, 8'hFF);
    fall_262144();
    chk_read(2'b01, 8'h00, "ovf_zero");
    check("ovf_irq_low", {7'd0, int_timer}, 8'h00);
    step();
    chk_read(2'b01, 8'hC0, "reload_val");
    check("reload_irq", {7'd0, int_timer}, 8'h01);
    check("model_reload", m_tima[7:0], 8'hC0);
    step();
    chk_read(2'b01, 8'hC0, "post_reload");
    check("irq_drop", {7'd0, int_timer}, 8'h00);
    step();

    // cancel during OVF
    irq0 = irq_cnt;
    wr(2'b01, 8'hFF);
    fall_262144();
    wr(2'b01, 8'h33);
    step();
    chk_read(2'b01, 8'h33, "cancel_val");
    check("cancel_noirq", 8'(irq_cnt - irq0), 8'h00);
    step();

    // TIMA write in RELOAD ignored
    wr(2'b01, 8'hFF);
    fall_262144();
    step();
    wr(2'b01, 8'h55);
    chk_read(2'b01, 8'hC0, "reload_wr_tima");
    step();

    // TMA write in RELOAD loads TIMA too
    wr(2'b01, 8'hFF);
    fall_262144();
    step();
    wr(2'b10, 8'h77);
    chk_read(2'b01, 8'h77, "reload_wr_tma_tima");
    chk_read(2'b10, 8'h77, "reload_wr_tma_tma");
    step();

    // disabling TAC while tap high ticks once
    wr(2'b01, 8'h00);
    tap_262144 = 1'b1;
    step();
    wr(2'b11, 8'h01);
    step();
    chk_read(2'b01, 8'h01, "tac_off_tick");
    step();
    tap_262144 = 1'b0;

    // DIV reset pulling taps low ticks once
    wr(2'b11, 8'h05);
    tap_262144 = 1'b1;
    step();
    tap_262144 = 1'b0;
    tap_4096 = 1'b0;
    tap_65536 = 1'b0;
    tap_16384 = 1'b0;
    step();
    chk_read(2'b01, 8'h02, "div_rst_tick");
    step();

    // reset while in OVF
    irq0 = irq_cnt;
    wr(2'b01, 8'hFF);
    fall_262144();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk_read(2'b01, 8'h00, "ovf_rst_tima");
    chk_read(2'b11, 8'hF8, "ovf_rst_tac");
    check("ovf_rst_noirq", 8'(irq_cnt - irq0), 8'h00);
    step();

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) tap_4096 = ~tap_4096;
      if ($urandom_range(0, 3) == 0) tap_262144 = ~tap_262144;
      if ($urandom_range(0, 3) == 0) tap_65536 = ~tap_65536;
      if ($urandom_range(0, 3) == 0) tap_16384 = ~tap_16384;
      ff04_ff07  = ($urandom_range(0, 3) != 0);
      tola_na1   = 1'($urandom_range(0, 1));
      tovy_na0   = 1'($urandom_range(0, 1));
      cpu_wr     = ($urandom_range(0, 5) == 0);
      cpu_rd     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        d_in = 8'(8'hFF - $urandom_range(0, 2));
      else
        d_in = 8'($urandom_range(0, 255));
      step();
    end
    reset  = 1'b0;
    cpu_wr = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
